// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: accepts ALU commands over valid/ready and emits registered datapath control words.
// Define ALU_CTRL_SHIFT_EN to build shift expansion (opcodes 8-10); otherwise those opcodes are illegal.
//
// state | meaning
// IDLE  | ready for a new command; output word (if any) is single-word or the last shift word
// SHIFT | emitting words 2..k of a multi-word shift; commands are blocked
module alu_ctrl_seq #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd,
  input  logic [$clog2(WIDTH)-1:0]  shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                sel,
  output logic                      invert,
  output logic                      slt_op,
  output logic                      shift_dir,
  output logic                      shift_arith,
  output logic                      last,
  output logic                      err_pulse,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic       accept;
  logic       illegal;
  logic [2:0] dec_sel;
  logic       dec_inv;
  logic       dec_slt;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    dec_sel = 3'd0;
    dec_inv = 1'b0;
    dec_slt = 1'b0;
    case (cmd)
      4'd1: dec_inv = 1'b1;
      4'd2: dec_sel = 3'd5;
      4'd3: begin
        dec_inv = 1'b1;
        dec_slt = 1'b1;
      end
      4'd4: dec_sel = 3'd1;
      4'd5: dec_sel = 3'd2;
      4'd6: dec_sel = 3'd3;
      4'd7: dec_sel = 3'd4;
      default: ;
    endcase
  end

`ifdef ALU_CTRL_SHIFT_EN
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic               is_shift;

  assign is_shift  = (cmd >= 4'd8) && (cmd <= 4'd10);
  assign illegal   = (cmd > 4'd10);
  assign cmd_ready = !reset && (state == IDLE) && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      sel         <= 3'd0;
      invert      <= 1'b0;
      slt_op      <= 1'b0;
      shift_dir   <= 1'b0;
      shift_arith <= 1'b0;
      last        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !illegal) begin
            out_valid <= 1'b1;
            if (is_shift) begin
              sel         <= 3'd6;
              invert      <= 1'b0;
              slt_op      <= 1'b0;
              shift_dir   <= (cmd != 4'd8);
              shift_arith <= (cmd == 4'd10);
              last        <= (shamt < SHAMT_W'(2));
              if (shamt >= SHAMT_W'(2)) begin
                cnt   <= shamt - SHAMT_W'(1);
                state <= SHIFT;
              end
            end else begin
              sel         <= dec_sel;
              invert      <= dec_inv;
              slt_op      <= dec_slt;
              shift_dir   <= 1'b0;
              shift_arith <= 1'b0;
              last        <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          // out_valid is always set here; each consume loads the next one-bit shift word
          if (out_ready) begin
            last <= (cnt == SHAMT_W'(1));
            cnt  <= cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_shamt;

  assign unused_shamt = ^shamt;
  assign illegal      = (cmd > 4'd7);
  assign cmd_ready    = !reset && (!out_valid || out_ready);
  assign shift_dir    = 1'b0;
  assign shift_arith  = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sel       <= 3'd0;
      invert    <= 1'b0;
      slt_op    <= 1'b0;
      last      <= 1'b0;
    end else if (accept && !illegal) begin
      out_valid <= 1'b1;
      sel       <= dec_sel;
      invert    <= dec_inv;
      slt_op    <= dec_slt;
      last      <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Illegal commands never touch the output stage; they only pulse and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= accept && illegal;
      if (accept && illegal && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver pushes expected words/error counts, monitor pops on handshakes.
module tb_alu_ctrl_seq;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic [SW-1:0] shamt = '0;
  logic          cmd_ready, out_valid, invert, slt_op, shift_dir, shift_arith, last, err_pulse;
  logic [2:0]    sel;
  logic [7:0]    err_cnt;
  logic [7:0]    dword;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   err_exp = 0;
  bit   rnd_ready = 1'b0;
  logic [7:0] wq[$];
  int   eq[$];
  bit   hold_pending = 1'b0;
  logic [7:0] held = '0;

  logic [2:0] sel_tab [0:7] = '{3'd0, 3'd0, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign dword = {sel, invert, slt_op, shift_dir, shift_arith, last};

  alu_ctrl_seq dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .invert(invert),
    .slt_op(slt_op), .shift_dir(shift_dir), .shift_arith(shift_arith), .last(last),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: legal ops give one word from the table, shifts give max(k,1) words, illegal ops bump the count.
  function automatic void model(input logic [3:0] c, input int s);
    bit shift_ok;
    int k;
`ifdef ALU_CTRL_SHIFT_EN
    shift_ok = 1'b1;
`else
    shift_ok = 1'b0;
`endif
    if (c <= 4'd7) begin
      wq.push_back({sel_tab[c[2:0]], (c == 4'd1) || (c == 4'd3), c == 4'd3, 3'b001});
    end else if (shift_ok && c <= 4'd10) begin
      k = (s == 0) ? 1 : s;
      for (int i = 1; i <= k; i++)
        wq.push_back({3'd6, 2'b00, c != 4'd8, c == 4'd10, i == k});
    end else begin
      if (err_exp < 255) err_exp++;
      eq.push_back(err_exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [3:0] c, input int s, output int acc_cyc);
    int waitn = 0;
    acc_cyc = 0;
    cmd_valid = 1'b1;
    cmd = c;
    shamt = SW'(s);
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      tick();
      waitn++;
      if (waitn > 500) begin
        chk("accept_timeout", waitn, 0);
        cmd_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    model(c, s);
    tick();
    cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_word", dword, held);
      end
      hold_pending = out_valid && !out_ready;
      held = dword;
      chk("cmd_ready", cmd_ready, !out_valid || (wq.size() > 0 && wq[0][0] && out_ready));
      if (out_valid) begin
        if (wq.size() == 0) chk("spurious_valid", out_valid, 1'b0);
        else if (out_ready) chk("word", dword, wq.pop_front());
      end
      if (err_pulse) begin
        if (eq.size() == 0) chk("spurious_err_pulse", err_pulse, 1'b0);
        else chk("err_cnt_at_pulse", err_cnt, eq.pop_front());
      end
    end
  end

  initial begin
    int a0, a1, a2, a3, ac;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_word", dword, 8'd0);
    chk("rst_err", {err_pulse, err_cnt}, 9'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("post_rst_ready", cmd_ready, 1'b1);

    // back-to-back single-word commands
    out_ready = 1'b1;
    issue(4'd0, 0, a0);
    issue(4'd1, 0, a1);
    issue(4'd3, 0, a2);
    issue(4'd2, 0, a3);
    chk("b2b_span", a3 - a0, 3);
    repeat (2) tick();

    // backpressure on NOR
    issue(4'd6, 0, ac);
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("nor_held", {out_valid, sel}, {1'b1, 3'd3});
      chk("nor_block", cmd_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("nor_consumed", out_valid, 1'b0);

`ifdef ALU_CTRL_SHIFT_EN
    issue(4'd10, 5, a0);
    issue(4'd4, 0, a1);
    chk("sra_and_gap", a1 - a0, 5);
    issue(4'd8, 0, ac);
    repeat (2) tick();
`endif

    // illegal flood to saturation
    rnd_ready = 1'b1;
    issue(4'd12, 0, ac);
    issue(4'd9, 0, ac);
    issue(4'd13, 0, ac);
    repeat (300) issue(4'($urandom_range(11, 15)), 0, ac);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("err_saturated", err_cnt, 8'd255);

    // reset in the middle of output activity
`ifdef ALU_CTRL_SHIFT_EN
    issue(4'd9, 7, ac);
    repeat (2) tick();
`else
    issue(4'd7, 0, ac);
    out_ready = 1'b0;
    repeat (2) tick();
`endif
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    chk("mid_rst_err", err_cnt, 8'd0);
    wq.delete();
    eq.delete();
    err_exp = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    #1 chk("mid_rst_idle", cmd_ready, 1'b1);
    issue(4'd0, 0, ac);
    chk("after_rst_add", {out_valid, sel, last}, {1'b1, 3'd0, 1'b1});
    repeat (2) tick();

    // randomized traffic with random backpressure
    rnd_ready = 1'b1;
    repeat (400) begin
      issue(4'($urandom_range(0, 15)), $urandom_range(0, 9), ac);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("words_left", wq.size(), 0);
    chk("err_left", eq.size(), 0);
    chk("final_err_cnt", err_cnt, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
